icmp_reply_tx: RTL and testbench

ICMP echo-reply frame generator for the UDP/IP transmit path. A single-cycle trigger causes it to emit one 40-byte ICMP echo-reply message (8-byte header plus 32-byte fixed payload) as an 8-bit byte stream. The checksum is computed in hardware. The stream feeds the IP transmitter with protocol type 1 (ICMP), which prepends the IP header, and the MAC transmitter after it.

---
 rtl/icmp_reply_tx.sv | 121 ++++++++++++
 tb/tb_icmp_reply_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_reply_tx.sv
// ICMP echo-reply generator: one trigger emits a 40-byte message (8-byte header
// plus 32-byte fixed payload) as a registered byte stream with hardware checksum.
module icmp_reply_tx #(
  parameter logic [15:0] P_IDENTIFIER = 16'h0001
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trig_reply,
  input  logic [15:0] i_trig_seq,
  output logic [7:0]  o_icmp_data,
  output logic [15:0] o_icmp_len,
  output logic        o_icmp_last,
  output logic        o_icmp_valid
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND} state_t;

  // Folded one's-complement sum of the 16 payload words.
  localparam logic [15:0] PAYLOAD_SUM = 16'hACA3;
  localparam logic [5:0]  LAST_IDX    = 6'd39;
  localparam logic [15:0] MSG_LEN     = 16'd40;

  state_t      state, state_nx;
  logic [5:0]  byte_cnt;
  logic [15:0] seq_q;
  logic [15:0] csum_q;
  logic [7:0]  byte_sel;
  logic [7:0]  data_nx;
  logic [15:0] len_nx;
  logic        last_nx;
  logic        valid_nx;

  // Two end-around folds suffice: three 16-bit terms carry at most 2 into bit 16.
  function automatic logic [15:0] calc_csum(input logic [15:0] seq);
    logic [17:0] s;
    logic [16:0] t;
    logic [15:0] u;
    s = {2'b00, PAYLOAD_SUM} + {2'b00, P_IDENTIFIER} + {2'b00, seq};
    t = {1'b0, s[15:0]} + {15'b0, s[17:16]};
    u = t[15:0] + {15'b0, t[16]};
    return ~u;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_trig_reply) state_nx = S_CALC;
      S_CALC:  state_nx = S_SEND;
      S_SEND:  if (byte_cnt == LAST_IDX) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt <= '0;
      seq_q    <= '0;
      csum_q   <= '0;
    end else begin
      if (state == S_IDLE && i_trig_reply) seq_q <= i_trig_seq;
      if (state == S_CALC) csum_q <= calc_csum(seq_q);
      if (state == S_SEND && byte_cnt != LAST_IDX) byte_cnt <= byte_cnt + 6'd1;
      else                                         byte_cnt <= '0;
    end
  end

  // Payload is "a".."w" at bytes 8..30, then "a".."i" at bytes 31..39.
  always_comb begin
    byte_sel = 8'h00;
    case (byte_cnt)
      6'd0, 6'd1: byte_sel = 8'h00;
      6'd2:       byte_sel = csum_q[15:8];
      6'd3:       byte_sel = csum_q[7:0];
      6'd4:       byte_sel = P_IDENTIFIER[15:8];
      6'd5:       byte_sel = P_IDENTIFIER[7:0];
      6'd6:       byte_sel = seq_q[15:8];
      6'd7:       byte_sel = seq_q[7:0];
      default: begin
        if (byte_cnt < 6'd31) byte_sel = 8'h59 + {2'b00, byte_cnt};
        else                  byte_sel = 8'h42 + {2'b00, byte_cnt};
      end
    endcase
  end

  always_comb begin
    data_nx  = 8'h00;
    len_nx   = 16'h0000;
    last_nx  = 1'b0;
    valid_nx = 1'b0;
    if (state == S_SEND) begin
      data_nx  = byte_sel;
      len_nx   = MSG_LEN;
      last_nx  = (byte_cnt == LAST_IDX);
      valid_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_icmp_data  <= '0;
      o_icmp_len   <= '0;
      o_icmp_last  <= 1'b0;
      o_icmp_valid <= 1'b0;
    end else begin
      o_icmp_data  <= data_nx;
      o_icmp_len   <= len_nx;
      o_icmp_last  <= last_nx;
      o_icmp_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_icmp_reply_tx.sv
// Self-checking bench for icmp_reply_tx: message-level model compared every
// cycle, plus literal byte expectations for the directed trigger scenarios.
module tb_icmp_reply_tx;

  localparam logic [15:0] P_ID        = 16'h0001;
  localparam logic [15:0] PAYLOAD_SUM = 16'hACA3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_trig_reply = 1'b0;
  logic [15:0] i_trig_seq = 16'h0000;
  logic [7:0]  o_icmp_data;
  logic [15:0] o_icmp_len;
  logic        o_icmp_last;
  logic        o_icmp_valid;

  icmp_reply_tx #(.P_IDENTIFIER(P_ID)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_trig_reply (i_trig_reply),
    .i_trig_seq   (i_trig_seq),
    .o_icmp_data  (o_icmp_data),
    .o_icmp_len   (o_icmp_len),
    .o_icmp_last  (o_icmp_last),
    .o_icmp_valid (o_icmp_valid)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ones_fold(input int unsigned s);
    int unsigned v;
    logic [31:0] w;
    v = s;
    while (v > 32'h0000_FFFF) v = (v & 32'h0000_FFFF) + (v >> 16);
    w = v;
    return w[15:0];
  endfunction

  // ---------------- behavioural model ----------------
  string       payload = "abcdefghijklmnopqrstuvwabcdefghi";
  int          edge_n = 0;
  int          busy_until = 0;
  int          accept_edge = -1;
  logic [7:0]  exp_data [int];
  logic        exp_last [int];

  function automatic void add_msg(input int k, input logic [15:0] seq);
    logic [15:0] cs;
    logic [7:0]  b [40];
    cs = ~ones_fold(32'(PAYLOAD_SUM) + 32'(P_ID) + 32'(seq));
    b[0] = 8'h00;        b[1] = 8'h00;
    b[2] = cs[15:8];     b[3] = cs[7:0];
    b[4] = P_ID[15:8];   b[5] = P_ID[7:0];
    b[6] = seq[15:8];    b[7] = seq[7:0];
    for (int i = 0; i < 32; i++) b[8+i] = payload[i];
    for (int i = 0; i < 40; i++) begin
      exp_data[k+2+i] = b[i];
      exp_last[k+2+i] = (i == 39);
    end
  endfunction

  always @(posedge i_rst) begin
    exp_data.delete();
    exp_last.delete();
    busy_until = 0;
  end

  always @(posedge i_clk) begin
    edge_n = edge_n + 1;
    if (!i_rst && i_trig_reply && edge_n >= busy_until) begin
      add_msg(edge_n, i_trig_seq);
      accept_edge = edge_n;
      busy_until  = edge_n + 42;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [7:0] cap [$];
  int         n_last = 0;
  int         last_pos = -1;
  int         first_edge = -1;
  logic       prev_valid = 1'b0;

  always @(negedge i_clk) begin
    logic [7:0]  ed;
    logic        el, ev;
    ev = exp_data.exists(edge_n);
    ed = ev ? exp_data[edge_n] : 8'h00;
    el = ev ? exp_last[edge_n] : 1'b0;
    check("data",  32'(o_icmp_data),  32'(ed));
    check("valid", 32'(o_icmp_valid), 32'(ev));
    check("last",  32'(o_icmp_last),  32'(el));
    check("len",   32'(o_icmp_len),   ev ? 32'd40 : 32'd0);
    if (o_icmp_valid) cap.push_back(o_icmp_data);
    if (o_icmp_valid && !prev_valid) first_edge = edge_n;
    if (o_icmp_last) begin
      n_last++;
      last_pos = cap.size() - 1;
    end
    prev_valid = o_icmp_valid;
  end

  // Called at a negedge; trigger is sampled on the following posedge.
  task automatic trig(input logic [15:0] seq);
    i_trig_reply = 1'b1;
    i_trig_seq   = seq;
    @(negedge i_clk);
    i_trig_reply = 1'b0;
  endtask

  task automatic clear_capture();
    cap.delete();
    n_last   = 0;
    last_pos = -1;
  endtask

  logic [7:0] hdr_s0 [8] = '{8'h00, 8'h00, 8'h53, 8'h5B, 8'h00, 8'h01, 8'h00, 8'h00};

  initial begin
    int unsigned s;
    bit          hit;

    repeat (3) @(negedge i_clk);
    check("rst_data",  32'(o_icmp_data),  32'd0);
    check("rst_valid", 32'(o_icmp_valid), 32'd0);
    check("rst_len",   32'(o_icmp_len),   32'd0);
    check("rst_last",  32'(o_icmp_last),  32'd0);
    i_rst = 1'b0;
    repeat (100) @(negedge i_clk);
    check("idle_no_bytes", 32'(cap.size()), 32'd0);

    // seq 0x0000
    clear_capture();
    trig(16'h0000);
    repeat (45) @(negedge i_clk);
    check("s0_count", 32'(cap.size()), 32'd40);
    check("s0_latency", 32'(first_edge - accept_edge), 32'd2);
    check("s0_nlast", 32'(n_last), 32'd1);
    check("s0_lastpos", 32'(last_pos), 32'd39);
    if (cap.size() == 40) begin
      for (int i = 0; i < 8; i++) check($sformatf("s0_hdr%0d", i), 32'(cap[i]), 32'(hdr_s0[i]));
      check("s0_b8",  32'(cap[8]),  32'h61);
      check("s0_b30", 32'(cap[30]), 32'h77);
      check("s0_b31", 32'(cap[31]), 32'h61);
      check("s0_b39", 32'(cap[39]), 32'h69);
    end

    // seq 0x0001
    clear_capture();
    trig(16'h0001);
    repeat (45) @(negedge i_clk);
    check("s1_count", 32'(cap.size()), 32'd40);
    if (cap.size() == 40) begin
      check("s1_csum", 32'({cap[2], cap[3]}), 32'h535A);
      check("s1_seq",  32'({cap[6], cap[7]}), 32'h0001);
    end

    // seq 0xFFFF: end-around carry
    clear_capture();
    trig(16'hFFFF);
    repeat (45) @(negedge i_clk);
    check("sf_count", 32'(cap.size()), 32'd40);
    if (cap.size() == 40) begin
      check("sf_csum", 32'({cap[2], cap[3]}), 32'h535B);
      s = 32'(PAYLOAD_SUM);
      for (int i = 0; i < 4; i++) s += 32'({cap[2*i], cap[2*i+1]});
      check("sf_total_sum", 32'(ones_fold(s)), 32'h0000FFFF);
    end

    // trigger at +10 ignored, trigger at +42 accepted
    clear_capture();
    trig(16'h1234);
    repeat (9) @(negedge i_clk);
    trig(16'h5678);
    repeat (31) @(negedge i_clk);
    trig(16'h9ABC);
    repeat (45) @(negedge i_clk);
    check("b2b_count", 32'(cap.size()), 32'd80);
    check("b2b_nlast", 32'(n_last), 32'd2);
    if (cap.size() == 80) begin
      check("b2b_seq1", 32'({cap[6], cap[7]}),   32'h1234);
      check("b2b_seq2", 32'({cap[46], cap[47]}), 32'h9ABC);
      check("b2b_b79",  32'(cap[79]),            32'h69);
    end

    // reset asserted while byte 20 is on the bus
    clear_capture();
    trig(16'h4321);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge i_clk);
      #1;
      if (cap.size() == 21) hit = 1'b1;
    end
    check("byte20_reached", 32'(hit), 32'd1);
    #1 i_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_icmp_valid), 32'd0);
    check("midrst_data",  32'(o_icmp_data),  32'd0);
    check("midrst_len",   32'(o_icmp_len),   32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);
    check("post_rst_idle", 32'(cap.size()), 32'd21);
    clear_capture();
    trig(16'h00AA);
    repeat (45) @(negedge i_clk);
    check("post_count", 32'(cap.size()), 32'd40);
    check("post_nlast", 32'(n_last), 32'd1);
    if (cap.size() == 40) begin
      check("post_csum", 32'({cap[2], cap[3]}), 32'h52B1);
      check("post_seq",  32'({cap[6], cap[7]}), 32'h00AA);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
